// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, TX state encoding, default bit timing.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 217;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered count/full/empty; head word is read combinationally.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_n;
    logic             do_push;
    logic             do_pop;

    // full is registered, so a push is refused while full even if a pop lands on the same edge
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_n = count;
        if (do_push && !do_pop) begin
            count_n = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_n = count - CW'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_n;
            full  <= (count_n == CW'(DEPTH));
            empty <= (count_n == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// Buffered UART transmitter with configurable data width, parity and stop bits.
module uart_tx_fifo_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_tx_dv,
    input  logic [DATA_BITS-1:0]              i_tx_byte,
    output logic                              o_tx_ready,
    output logic                              o_tx_serial,
    output logic                              o_tx_active,
    output logic                              o_tx_done,
    output logic                              o_overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count
);

    localparam int CW = $clog2(CLKS_PER_BIT * 2);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    tx_state_t              state, state_n;
    logic [CW-1:0]          clk_cnt, cnt_n;
    logic [BW-1:0]          bit_idx, bit_n;
    logic [DATA_BITS-1:0]   shift, shift_n;
    logic [DATA_BITS-1:0]   fifo_head;
    logic                   fifo_full, fifo_empty;
    logic                   pop;
    logic                   bit_end;
    logic                   par_bit;
    logic                   line_n, active_n, done_n;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .wr_en   (i_tx_dv),
        .wr_data (i_tx_byte),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (o_fifo_count)
    );

    assign o_tx_ready = !fifo_full;
    assign bit_end    = (clk_cnt == CNT_LAST);
    // parity comes from the word latched at pop, not from the live input
    assign par_bit    = (PARITY == PAR_EVEN) ? ^shift : ~^shift;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n  = state;
        cnt_n    = bit_end ? '0 : clk_cnt + CW'(1);
        bit_n    = bit_idx;
        shift_n  = shift;
        pop      = 1'b0;
        line_n   = 1'b1;
        active_n = 1'b1;
        done_n   = 1'b0;
        case (state)
            TX_IDLE: begin
                active_n = 1'b0;
                cnt_n    = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_head;
                    bit_n   = '0;
                    state_n = TX_START;
                end
            end
            TX_START: begin
                line_n = 1'b0;
                if (bit_end) state_n = TX_DATA;
            end
            TX_DATA: begin
                line_n = shift[bit_idx];
                if (bit_end) begin
                    if (bit_idx == DATA_LAST) begin
                        bit_n   = '0;
                        state_n = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
                    end else begin
                        bit_n = bit_idx + BW'(1);
                    end
                end
            end
            TX_PARITY: begin
                line_n = par_bit;
                if (bit_end) begin
                    bit_n   = '0;
                    state_n = TX_STOP;
                end
            end
            TX_STOP: begin
                // bit_idx counts stop bits; the last one chains straight into the next start bit
                if (bit_end) begin
                    if (bit_idx == STOP_LAST) begin
                        done_n = 1'b1;
                        bit_n  = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_n = fifo_head;
                            state_n = TX_START;
                        end else begin
                            state_n = TX_IDLE;
                        end
                    end else begin
                        bit_n = bit_idx + BW'(1);
                    end
                end
            end
            default: begin
                active_n = 1'b0;
                cnt_n    = '0;
                bit_n    = '0;
                state_n  = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= TX_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_tx_serial <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            state       <= state_n;
            clk_cnt     <= cnt_n;
            bit_idx     <= bit_n;
            shift       <= shift_n;
            o_tx_serial <= line_n;
            o_tx_active <= active_n;
            o_tx_done   <= done_n;
            o_overflow  <= i_tx_dv && fifo_full;
        end
    end

endmodule
